// File: rtl/debug_seq_pkg.sv
// Shared types for the debug-port sequencer:
// op codes, register selects, FSM states, strobe bundle.
package debug_seq_pkg;

  localparam int ACK_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    OP_WR_MEM = 3'd0,
    OP_RD_MEM = 3'd1,
    OP_WR_A   = 3'd2,
    OP_WR_B   = 3'd3,
    OP_WR_PC  = 3'd4,
    OP_WR_OUT = 3'd5,
    OP_RD_REG = 3'd6,
    OP_CLEAR  = 3'd7
  } op_e;

  localparam logic [2:0] SEL_A = 3'd0;
  localparam logic [2:0] SEL_B = 3'd1;
  localparam logic [2:0] SEL_C = 3'd2;
  localparam logic [2:0] SEL_I = 3'd3;
  localparam logic [2:0] SEL_E = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ,
    S_X1,
    S_X2,
    S_RSP,
    S_REL
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    logic clr;
    logic ri;
    logic ain;
    logic bin;
    logic oin;
    logic jn;
    logic min;
    logic don;
    logic aon;
    logic bon;
    logic ion;
    logic con;
    logic eon;
    logic ron;
  } dbg_t;

  localparam dbg_t DBG_OFF = '{
    data: 8'h00, clr: 1'b0, ri: 1'b0,
    ain: 1'b1, bin: 1'b1, oin: 1'b1,
    jn: 1'b1, min: 1'b1, don: 1'b1,
    aon: 1'b1, bon: 1'b1, ion: 1'b1,
    con: 1'b1, eon: 1'b1, ron: 1'b1
  };

  function automatic logic sel_ok(logic [7:0] addr);
    return addr[2:0] <= SEL_E;
  endfunction

  function automatic logic two_step(op_e op);
    return op == OP_WR_MEM || op == OP_RD_MEM;
  endfunction

  // Strobe pattern for one execute step of a latched command.
  function automatic dbg_t step_out(
    state_e     st,
    op_e        op,
    logic [7:0] addr,
    logic [7:0] data
  );
    dbg_t d;
    d = DBG_OFF;
    unique case (1'b1)
      st == S_X1: begin
        unique case (op)
          OP_WR_MEM, OP_RD_MEM: begin
            d.data = addr;
            d.don  = 1'b0;
            d.min  = 1'b0;
          end
          OP_WR_A: begin
            d.data = data;
            d.don  = 1'b0;
            d.ain  = 1'b0;
          end
          OP_WR_B: begin
            d.data = data;
            d.don  = 1'b0;
            d.bin  = 1'b0;
          end
          OP_WR_PC: begin
            d.data = data;
            d.don  = 1'b0;
            d.jn   = 1'b0;
          end
          OP_WR_OUT: begin
            d.data = data;
            d.don  = 1'b0;
            d.oin  = 1'b0;
          end
          OP_RD_REG: begin
            case (addr[2:0])
              SEL_A:   d.aon = 1'b0;
              SEL_B:   d.bon = 1'b0;
              SEL_C:   d.con = 1'b0;
              SEL_I:   d.ion = 1'b0;
              SEL_E:   d.eon = 1'b0;
              default: d.aon = 1'b1;
            endcase
          end
          OP_CLEAR: d.clr = 1'b1;
        endcase
      end
      st == S_X2: begin
        if (op == OP_WR_MEM) begin
          d.data = data;
          d.don  = 1'b0;
          d.ri   = 1'b1;
        end
        if (op == OP_RD_MEM) d.ron = 1'b0;
      end
      default: d = DBG_OFF;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/debug_sequencer_if.sv
// Host-side command/response handshake of the
// debug sequencer, plus the keep-frozen HOLD level.
interface debug_sequencer_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [2:0] CMD_OP;
  logic [7:0] CMD_ADDR;
  logic [7:0] CMD_DATA;
  logic       HOLD;
  logic       RSP_VALID;
  logic [7:0] RSP_DATA;
  logic       RSP_ERR;

  modport master (
    output CMD_VALID, CMD_OP, CMD_ADDR,
    output CMD_DATA, HOLD,
    input  CMD_READY, RSP_VALID,
    input  RSP_DATA, RSP_ERR
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_ADDR,
    input  CMD_DATA, HOLD,
    output CMD_READY, RSP_VALID,
    output RSP_DATA, RSP_ERR
  );
endinterface

// File: rtl/debug_ack_timer.sv
// Bounded wait counter for the DEBUG_ACK handshake;
// expired is high during the LIMIT-th enabled cycle.
module debug_ack_timer #(
  parameter int LIMIT = 64
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(LIMIT - 1));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/debug_sequencer.sv
// Owns the core debug port: acquires the core,
// drives one strobe pattern per command, responds once.
module debug_sequencer
  import debug_seq_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic       CLK,
  input  logic       RESETn,
  debug_sequencer_if.slave cmd,
  output logic       DEBUG_REQUEST,
  input  logic       DEBUG_ACK,
  output logic [7:0] DEBUG_DATA,
  output logic       D_CLR,
  output logic       D_HLT,
  output logic       D_CE,
  output logic       D_SU,
  output logic       D_RI,
  output logic       D_AIn,
  output logic       D_BIn,
  output logic       D_OIn,
  output logic       D_IIn,
  output logic       D_Jn,
  output logic       D_FIn,
  output logic       D_MIn,
  output logic       D_DOn,
  output logic       D_AOn,
  output logic       D_BOn,
  output logic       D_IOn,
  output logic       D_COn,
  output logic       D_EOn,
  output logic       D_ROn,
  output logic       D_NOn,
  input  logic [7:0] BUS
);
  state_e     state;
  op_e        op_q;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  dbg_t       dbg;
  logic       req;
  logic       rsp_valid;
  logic       rsp_err;
  logic [7:0] rsp_data;

  op_e  op_in;
  logic accept;
  logic bad_sel;
  logic tmr_en;
  logic expired;

  assign op_in   = op_e'(cmd.CMD_OP);
  assign accept  = cmd.CMD_VALID && (state == S_IDLE);
  assign bad_sel = (op_in == OP_RD_REG) &&
                   !sel_ok(cmd.CMD_ADDR);
  assign tmr_en  = (state == S_ACQ) || (state == S_REL);

  debug_ack_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_timer (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .load    (!tmr_en),
    .en      (tmr_en),
    .expired (expired)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= S_IDLE;
      op_q      <= OP_WR_MEM;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      dbg       <= DBG_OFF;
      req       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      dbg       <= DBG_OFF;
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          req <= cmd.HOLD;
          if (accept) begin
            op_q   <= op_in;
            addr_q <= cmd.CMD_ADDR;
            data_q <= cmd.CMD_DATA;
            if (bad_sel) begin
              state     <= S_RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 8'h00;
            end else if (DEBUG_ACK) begin
              state <= S_X1;
              req   <= 1'b1;
              dbg   <= step_out(S_X1, op_in,
                                cmd.CMD_ADDR,
                                cmd.CMD_DATA);
            end else begin
              state <= S_ACQ;
              req   <= 1'b1;
            end
          end
        end
        S_ACQ: begin
          if (DEBUG_ACK) begin
            state <= S_X1;
            dbg   <= step_out(S_X1, op_q,
                              addr_q, data_q);
          end else if (expired) begin
            state     <= S_RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= 8'h00;
          end
        end
        S_X1: begin
          if (!DEBUG_ACK) begin
            state     <= S_RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= 8'h00;
          end else if (two_step(op_q)) begin
            state <= S_X2;
            dbg   <= step_out(S_X2, op_q,
                              addr_q, data_q);
          end else begin
            state     <= S_RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= (op_q == OP_RD_REG) ?
                         BUS : 8'h00;
          end
        end
        S_X2: begin
          state     <= S_RSP;
          rsp_valid <= 1'b1;
          if (!DEBUG_ACK) begin
            rsp_err  <= 1'b1;
            rsp_data <= 8'h00;
          end else begin
            rsp_err  <= 1'b0;
            rsp_data <= (op_q == OP_RD_MEM) ?
                        BUS : 8'h00;
          end
        end
        S_RSP: state <= S_REL;
        // Hand the core back unless the host keeps it frozen.
        S_REL: begin
          if (cmd.HOLD) begin
            req   <= 1'b1;
            state <= S_IDLE;
          end else begin
            req <= 1'b0;
            if (!DEBUG_ACK || expired) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd.CMD_READY = (state == S_IDLE);
  assign cmd.RSP_VALID = rsp_valid;
  assign cmd.RSP_DATA  = rsp_data;
  assign cmd.RSP_ERR   = rsp_err;

  assign DEBUG_REQUEST = req;
  assign DEBUG_DATA    = dbg.data;
  assign D_CLR = dbg.clr;
  assign D_RI  = dbg.ri;
  assign D_AIn = dbg.ain;
  assign D_BIn = dbg.bin;
  assign D_OIn = dbg.oin;
  assign D_Jn  = dbg.jn;
  assign D_MIn = dbg.min;
  assign D_DOn = dbg.don;
  assign D_AOn = dbg.aon;
  assign D_BOn = dbg.bon;
  assign D_IOn = dbg.ion;
  assign D_COn = dbg.con;
  assign D_EOn = dbg.eon;
  assign D_ROn = dbg.ron;
  assign D_HLT = 1'b0;
  assign D_CE  = 1'b0;
  assign D_SU  = 1'b0;
  assign D_IIn = 1'b1;
  assign D_FIn = 1'b1;
  assign D_NOn = 1'b1;
endmodule

// File: doc/debug_sequencer.md
# debug_sequencer

Command-driven sequencer that owns the CPU core's debug port. It accepts one command at a time on a valid/ready interface and acquires the core through the DEBUG_REQUEST/DEBUG_ACK handshake. It then drives the exact D_* strobe and DEBUG_DATA pattern that writes or reads memory and registers, and returns a one-cycle response. It sits between the host-side command decoder and the core's debug inputs.

## Interface
- ACK_TIMEOUT, 64: cycles ACQ waits for DEBUG_ACK before erroring (≥2)
- CLK  in  1  clock; all state on rising edge
- RESETn  in  1  reset; asynchronous and active-low
- CMD_VALID  in  1  command present
- CMD_READY  out  1  high only in IDLE; command accepted on VALID&READY
- CMD_OP  in  3  0 WR_MEM, 1 RD_MEM, 2 WR_A, 3 WR_B, 4 WR_PC, 5 WR_OUT, 6 RD_REG, 7 CLEAR
- CMD_ADDR  in  8  memory address (WR_MEM/RD_MEM); RD_REG select in [2:0]
- CMD_DATA  in  8  write data
- HOLD  in  1  keep core frozen between commands
- RSP_VALID  out  1  one-cycle response strobe
- RSP_DATA  out  8  read data (0 for writes/errors), held until next RSP_VALID
- RSP_ERR  out  1  qualified by RSP_VALID
- DEBUG_REQUEST  out  1; DEBUG_ACK  in  1
- DEBUG_DATA  out  8  bus value when D_DOn=0
- D_CLR, D_HLT, D_CE, D_SU, D_RI  out  1 each, active-high
- D_AIn, D_BIn, D_OIn, D_IIn, D_Jn, D_FIn, D_MIn, D_DOn, D_AOn, D_BOn, D_IOn, D_COn, D_EOn, D_ROn, D_NOn  out  1 each, active-low
- BUS  in  8  core bus, sampled on reads

## Operation
- States: IDLE, ACQ, X1, X2, RSP, REL. Outputs decoded from registered state and latched command only; no input→output combinational path.
- Reset values: all active-high D_* 0, all active-low D_* 1, DEBUG_DATA 0, DEBUG_REQUEST 0, RSP_* 0, state IDLE. Outside X1/X2 every D_* is inactive. D_HLT, D_CE, D_SU, D_FIn, D_NOn are never asserted.
- IDLE: DEBUG_REQUEST=HOLD. On accept, latch op/addr/data. Goto ACQ, or directly to X1 if DEBUG_ACK already high. RD_REG select >4 goes to RSP with ERR, no port activity.
- ACQ: DEBUG_REQUEST=1; ACK sampled high → X1; counter reaches ACK_TIMEOUT → RSP with ERR.
- X1/X2 (DEBUG_REQUEST=1):
  - WR_MEM: X1 DEBUG_DATA=addr, D_DOn=0, D_MIn=0; X2 DEBUG_DATA=data, D_DOn=0, D_RI=1.
  - RD_MEM: X1 as WR_MEM; X2 D_ROn=0, RSP_DATA←BUS at X2 exit edge.
  - WR_A/WR_B/WR_PC/WR_OUT: X1 DEBUG_DATA=data, D_DOn=0, D_AIn/D_BIn/D_Jn/D_OIn=0; no X2.
  - RD_REG: X1 select 0 D_AOn, 1 D_BOn, 2 D_COn, 3 D_IOn, 4 D_EOn =0; RSP_DATA←BUS at X1 exit; no X2.
  - CLEAR: X1 D_CLR=1; no X2.
- DEBUG_ACK sampled low in X1/X2: abort to RSP with ERR, RSP_DATA=0; remaining step not issued.
- RSP: RSP_VALID=1 one cycle → REL.
- REL: HOLD=1 → IDLE with request kept high. HOLD=0 → DEBUG_REQUEST=0, wait ACK low (ACK_TIMEOUT bound, no error) → IDLE.

## Timing
- Core already acked (HOLD=1): single-step op accept→RSP_VALID = 2 cycles; two-step op = 3 cycles.
- Not acked: +1 cycle for the ACK registered in the core, plus any wait for core T0.
- Exactly one cycle per strobe step; never two D_* bus drivers (xOn/D_DOn) low in one cycle.
- CMD_VALID while busy: ignored, READY=0, command held by sender.
- Async reset mid-operation: outputs inactive immediately, request dropped, command lost, no response.
- Timeout counter cleared on every ACQ entry.

## Structure
- Package debug_seq_pkg: op encodings, RD_REG select codes, state enum, ACK_TIMEOUT default.
- One sub-module: debug_ack_timer (load/enable/expired counter used in ACQ and REL).

## Test plan
- HOLD=0, ACK one cycle after request; WR_MEM addr 0x0E data 0xA5 → X1 DOn=0/MIn=0/DEBUG_DATA=0x0E, X2 RI=1/DEBUG_DATA=0xA5, RSP_ERR=0, request drops.
- RD_MEM addr 0x0E, BUS model returns 0xA5 while ROn=0 → RSP_DATA=0xA5, ERR=0.
- HOLD=1, WR_A 0x3C then RD_REG sel 0 back-to-back → no request deassertion, AOn=0 cycle, RSP_DATA=0x3C, 2-cycle latency each.
- ACK never asserts, ACK_TIMEOUT=8 → RSP_VALID with ERR=1 after 8 ACQ cycles, no D_* activity.
- ACK dropped during X1 of WR_MEM → no RI pulse, RSP_ERR=1; RD_REG sel 6 → ERR with no request.
- RESETn low during X2 → all D_* inactive and DEBUG_REQUEST=0 same cycle; after release CMD_READY=1, no RSP_VALID.
